// File: rtl/home_clock_bcd.sv
// 24-hour BCD time-of-day counter. It divides the board clock into simulated seconds
// and emits one-cycle second, midnight and rejected-load pulses.
module home_clock_bcd #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  output logic [3:0] hour_d1,
  output logic [3:0] hour_d0,
  output logic [3:0] min_d1,
  output logic [3:0] min_d0,
  output logic [3:0] sec_d1,
  output logic [3:0] sec_d0,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          load_ok;
  logic          last_second;
  logic [3:0]    n_h1, n_h0, n_m1, n_m0, n_s1, n_s0;

  assign tick        = run && (pre == PRE_LAST);
  assign last_second = ({hour_d1, hour_d0, min_d1, min_d0, sec_d1, sec_d0} == 24'h235959);

  // Every nibble must be a decimal digit, hours at most 23, minutes at most 59.
  assign load_ok = (set_hh[7:4] <= 4'd2) && (set_hh[3:0] <= 4'd9) &&
                   ((set_hh[7:4] != 4'd2) || (set_hh[3:0] <= 4'd3)) &&
                   (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9);

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    n_s0 = sec_d0 + 4'd1;
    n_s1 = sec_d1;
    n_m0 = min_d0;
    n_m1 = min_d1;
    n_h0 = hour_d0;
    n_h1 = hour_d1;
    if (sec_d0 == 4'd9) begin
      n_s0 = 4'd0;
      n_s1 = sec_d1 + 4'd1;
      if (sec_d1 == 4'd5) begin
        n_s1 = 4'd0;
        n_m0 = min_d0 + 4'd1;
        if (min_d0 == 4'd9) begin
          n_m0 = 4'd0;
          n_m1 = min_d1 + 4'd1;
          if (min_d1 == 4'd5) begin
            n_m1 = 4'd0;
            n_h0 = hour_d0 + 4'd1;
            if (hour_d1 == 4'd2 && hour_d0 == 4'd3) begin
              n_h1 = 4'd0;
              n_h0 = 4'd0;
            end else if (hour_d0 == 4'd9) begin
              n_h0 = 4'd0;
              n_h1 = hour_d1 + 4'd1;
            end
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre      <= '0;
      hour_d1  <= 4'd0;
      hour_d0  <= 4'd0;
      min_d1   <= 4'd0;
      min_d0   <= 4'd0;
      sec_d1   <= 4'd0;
      sec_d0   <= 4'd0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // A load swallows any tick on the same edge; a rejected load also freezes pre.
        if (load_ok) begin
          pre     <= '0;
          hour_d1 <= set_hh[7:4];
          hour_d0 <= set_hh[3:0];
          min_d1  <= set_mm[7:4];
          min_d0  <= set_mm[3:0];
          sec_d1  <= 4'd0;
          sec_d0  <= 4'd0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run) begin
        if (tick) begin
          pre      <= '0;
          hour_d1  <= n_h1;
          hour_d0  <= n_h0;
          min_d1   <= n_m1;
          min_d0   <= n_m0;
          sec_d1   <= n_s1;
          sec_d0   <= n_s0;
          sec_tick <= 1'b1;
          day_wrap <= last_second;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_home_clock_bcd.sv
// Bench for home_clock_bcd: a seconds-of-day reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run/load phase.
module tb_home_clock_bcd;

  localparam int TICK_DIV = 4;

  logic       clock = 1'b0;
  logic       resetn, run, load;
  logic [7:0] set_hh, set_mm;
  logic [3:0] hour_d1, hour_d0, min_d1, min_d0, sec_d1, sec_d0;
  logic       sec_tick, day_wrap, load_err;

  int checks   = 0;
  int failures = 0;

  home_clock_bcd #(.TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .resetn(resetn), .run(run), .load(load),
    .set_hh(set_hh), .set_mm(set_mm),
    .hour_d1(hour_d1), .hour_d0(hour_d0), .min_d1(min_d1), .min_d0(min_d0),
    .sec_d1(sec_d1), .sec_d0(sec_d0),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Reference model: time as seconds since midnight, prescaler as a plain integer.
  int m_secs = 0;
  int m_pre  = 0;
  bit m_tick = 0, m_wrap = 0, m_err = 0;

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_valid(input logic [7:0] hh, input logic [7:0] mm);
    return hh[7:4] <= 4'd9 && hh[3:0] <= 4'd9 && mm[7:4] <= 4'd9 && mm[3:0] <= 4'd9 &&
           bcd_val(hh) <= 23 && bcd_val(mm) <= 59;
  endfunction

  function automatic logic [23:0] to_digits(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_secs = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_tick = 0; m_wrap = 0; m_err = 0;
      if (load) begin
        if (load_valid(set_hh, set_mm)) begin
          m_secs = bcd_val(set_hh) * 3600 + bcd_val(set_mm) * 60;
          m_pre  = 0;
        end else begin
          m_err = 1;
        end
      end else if (run) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre  = 0;
          m_secs = (m_secs + 1) % 86400;
          m_tick = 1;
          m_wrap = (m_secs == 0);
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] digits();
    return {hour_d1, hour_d0, min_d1, min_d0, sec_d1, sec_d0};
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (resetn === 1'b1)
      check("model", 32'({digits(), sec_tick, day_wrap, load_err}),
            32'({to_digits(m_secs), m_tick, m_wrap, m_err}));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] hh, input logic [7:0] mm);
    set_hh = hh;
    set_mm = mm;
    load   = 1'b1;
    cyc();
    load   = 1'b0;
  endtask

  task automatic wait_pre(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_pre == target) ok = 1;
      else cyc();
    end
  endtask

  task automatic cycles_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      cyc();
      if (sec_tick) n = i;
    end
  endtask

  initial begin
    int  ticks, wraps, n;
    bit  ok;
    logic [23:0] snap;
    logic [7:0]  bad_hh [3] = '{8'h24, 8'h12, 8'h12};
    logic [7:0]  bad_mm [3] = '{8'h34, 8'h5A, 8'h60};

    resetn = 1'b0; run = 1'b0; load = 1'b0; set_hh = 8'h00; set_mm = 8'h00;
    cyc(); cyc();
    check("reset_state", 32'({digits(), sec_tick, day_wrap, load_err}), 32'h0);
    resetn = 1'b1;
    run    = 1'b1;

    // Free run: 240 cycles give 60 ticks and 00:01:00.
    ticks = 0;
    repeat (240) begin
      cyc();
      if (sec_tick) ticks++;
    end
    check("free_run_ticks", 32'(ticks), 32'd60);
    check("free_run_time", 32'(digits()), 32'h000100);

    do_load(8'h09, 8'h59);
    repeat (240) cyc();
    check("hour_carry_10", 32'(digits()), 32'h100000);

    do_load(8'h19, 8'h59);
    repeat (236) cyc();
    check("at_195959", 32'(digits()), 32'h195959);
    repeat (4) cyc();
    check("hour_carry_20", 32'(digits()), 32'h200000);

    // Midnight wrap: exactly one day_wrap, only on the final tick.
    do_load(8'h23, 8'h59);
    wraps = 0;
    repeat (236) begin
      cyc();
      if (day_wrap) wraps++;
    end
    check("no_wrap_at_235959", 32'(wraps), 32'd0);
    check("at_235959", 32'(digits()), 32'h235959);
    repeat (4) begin
      cyc();
      if (day_wrap) begin
        wraps++;
        check("wrap_with_tick", 32'(sec_tick), 32'd1);
      end
    end
    check("wrap_count", 32'(wraps), 32'd1);
    check("midnight", 32'(digits()), 32'h000000);

    // Rejected loads leave 12:34:56 untouched.
    do_load(8'h12, 8'h34);
    repeat (224) cyc();
    run = 1'b0;
    check("at_123456", 32'(digits()), 32'h123456);
    for (int i = 0; i < 3; i++) begin
      do_load(bad_hh[i], bad_mm[i]);
      check("bad_load_err", 32'(load_err), 32'd1);
      check("bad_load_time", 32'(digits()), 32'h123456);
      cyc();
      check("bad_load_err_1cyc", 32'(load_err), 32'd0);
    end
    do_load(8'h23, 8'h59);
    check("good_load_err", 32'(load_err), 32'd0);
    check("good_load_time", 32'(digits()), 32'h235900);

    // Pause at pre=2: time holds, then the tick lands 2 cycles after resume.
    run = 1'b1;
    wait_pre(2, ok);
    check("reach_pre2", 32'(ok), 32'd1);
    run  = 1'b0;
    snap = to_digits(m_secs);
    repeat (10) cyc();
    check("pause_hold", 32'(digits()), 32'(snap));
    run = 1'b1;
    cycles_to_tick(n);
    check("resume_phase", 32'(n), 32'd2);

    // Load on a tick edge wins and suppresses sec_tick.
    wait_pre(TICK_DIV - 1, ok);
    check("reach_pre_last", 32'(ok), 32'd1);
    do_load(8'h07, 8'h30);
    check("collide_no_tick", 32'(sec_tick), 32'd0);
    check("collide_time", 32'(digits()), 32'h073000);

    // Asynchronous reset between edges.
    do_load(8'h15, 8'h42);
    repeat (28) cyc();
    check("at_154207", 32'(digits()), 32'h154207);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", 32'({digits(), sec_tick, day_wrap, load_err}), 32'h0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    cycles_to_tick(n);
    check("first_tick_after_reset", 32'(n), 32'(TICK_DIV));

    // Randomized run/load traffic, checked by the per-cycle compare.
    repeat (3000) begin
      run  = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: begin
          set_hh = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
          set_mm = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end
        1: begin set_hh = 8'h23; set_mm = 8'h59; end
        default: begin set_hh = 8'($urandom); set_mm = 8'($urandom); end
      endcase
      cyc();
    end
    load = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/home_clock_bcd.md
# home_clock_bcd

Time-of-day counter for the home simulation. It divides the board clock into simulated seconds and keeps hours, minutes and seconds as a 24-hour BCD clock. It exposes six 4-bit BCD digits that drive the `hex_decoder` instances directly, one digit per HEX display. It also emits one-cycle event pulses that other home-simulation logic uses for timed behaviour.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per simulated second. Legal range is ≥2; benches use 4.
- `clock`  in  1: system clock (CLOCK_50 on board).
- `resetn`  in  1: asynchronous, active-low reset.
- `run`  in  1: level. 1 = time advances; 0 = frozen.
- `load`  in  1: single-cycle strobe that loads `set_hh:set_mm:00`.
- `set_hh`  in  8: BCD hours, with [7:4] the tens digit and [3:0] the units digit.
- `set_mm`  in  8: BCD minutes, same digit layout.
- `hour_d1`, `hour_d0`, `min_d1`, `min_d0`, `sec_d1`, `sec_d0`  out  4 each: BCD digits, tens then units. Each feeds a `hex_decoder` `c` input.
- `sec_tick`  out  1: one-cycle pulse, asserted each time the seconds advance.
- `day_wrap`  out  1: one-cycle pulse on the 23:59:59 → 00:00:00 transition.
- `load_err`  out  1: one-cycle pulse when a `load` is rejected.

## Operation
- **Prescaler**
  - `pre` counts 0..`TICK_DIV`-1 while `run`=1 and holds its value while `run`=0.
  - A tick occurs on the edge where `pre`=`TICK_DIV`-1 and `run`=1. On that edge `pre` returns to 0.
- **On a tick**, the time advances by one second with BCD ripple carry:
  - `sec_d0` counts 9→0 and carries into `sec_d1`. `sec_d1` counts 5→0 and carries into the minutes.
  - Minutes follow the same 9→0 and 5→0 pattern and carry into the hours.
  - Hours run 00..23: 09→10, 19→20, 23→00.
- **Load validation**: a load is valid when `set_hh` ≤ 23 and `set_mm` ≤ 59, with every nibble ≤ 9.
- **Valid load**:
  - Digits become `set_hh`, `set_mm`, 00.
  - `pre` is cleared to 0.
  - The load takes effect regardless of `run`.
- **Invalid load**: time and `pre` are unchanged, and `load_err` pulses.
- **Priority**: `load` beats a tick on the same edge. The tick is discarded, with no `sec_tick` and no `day_wrap`. `pre` still clears, on a valid load only.
- **Illegal digit combinations** are unreachable, since they are only enterable through a validated load.
- **Registers**: all outputs are registered, with no combinational path from inputs to outputs.
- **Reset values**, all asynchronous:
  - Digits: 0, i.e. 00:00:00.
  - `pre`: 0.
  - `sec_tick`, `day_wrap`, `load_err`: 0.

## Timing
- **Tick latency**: the digits and `sec_tick` change on the same edge, the tick edge. `sec_tick` is high for exactly the one following cycle.
- **Tick period**: with `run` held at 1, consecutive `sec_tick` pulses are exactly `TICK_DIV` cycles apart.
  - After reset or a valid load, the first tick lands `TICK_DIV` run-cycles later.
- **`day_wrap`**: asserted in the same cycle as the `sec_tick` that produces 00:00:00.
- **Load latency**: digits or `load_err` update on the edge that samples `load`=1. A `load` held for N cycles acts as N loads.
- **Pausing**: deasserting `run` mid-count freezes `pre`. Reasserting it resumes from the frozen value, with no phase loss.
- **Reset mid-operation**: asserting `resetn` low forces all outputs to their reset values immediately, independent of `clock`.
  - Counting restarts from `pre`=0 on the first edge after release.

## Test plan
- **Free run**: `TICK_DIV`=4, reset, then `run`=1 for 240 cycles → 00:01:00. `sec_tick` pulses every 4 cycles, 60 pulses total; `sec_d1` counts 5→0 with carry into `min_d0`=1.
- **BCD hour carry**: load `set_hh`=8'h09, `set_mm`=8'h59, then 60 ticks → digits 1,0,0,0,0,0, i.e. 10:00:00. Also check 19:59:59 → 20:00:00.
- **Day wrap**: load 23:59 and run 60 ticks → 00:00:00. `day_wrap` pulses exactly once, coincident with the final `sec_tick`; it does not pulse at 23:59:59.
- **Invalid load**: from 12:34:56, load `set_hh`=8'h24 → `load_err` pulses for 1 cycle and time stays 12:34:56. Repeat with `set_mm`=8'h5A and with `set_mm`=8'h60 → same result. Load 8'h23/8'h59 → accepted, no `load_err`.
- **Pause, and load/tick collision**:
  - Drop `run` at `pre`=2 for 10 cycles → digits and `pre` hold; after resume the next tick is 2 cycles later.
  - Assert `load` on a tick edge → loaded value appears and no `sec_tick` pulses.
- **Async reset**: pull `resetn` low between clock edges while at 15:42:07 → all digits read 0 and pulses are 0 before the next edge. After release, the first `sec_tick` occurs `TICK_DIV` cycles later.
